// File: rtl/irq_ack_arbiter.sv
// Round-robin arbiter sharing one interrupt/enable-in acknowledge handshake among NREQ requesters.
// Define IRQ_ACK_ARBITER_TIMEOUT_EN to abort handshakes that stall for TMO_MAX cycles.
module irq_ack_arbiter #(
  parameter int NREQ    = 4,
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_intr,
  input  logic            eql,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      cc_mux,
  output logic [1:0]      uscite,
  output logic            busy,
  output logic [NREQ-1:0] done,
  output logic            timeout
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TMO_MAX < 1 || TMO_MAX >= (2 ** TMO_W)) begin : g_bad_params
    $error("irq_ack_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, REQ_WAIT, ACK_WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d, w_q, w_d;
  logic [IW-1:0]   pick_idx, scan_idx, w_next;
  logic            pick_found;
  logic            t_q, t_d;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d;
  logic [1:0]      cc_mux_q, cc_mux_d, uscite_q, uscite_d;
  logic            busy_q, busy_d;

`ifdef IRQ_ACK_ARBITER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TMO_MAX));
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign w_next = (w_q == IW'(NREQ - 1)) ? '0 : w_q + IW'(1);

  // First requester at or above the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = IW'((int'(rr_q) + i) % NREQ);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    t_d     = t_q;
    rr_d    = rr_q;
`ifdef IRQ_ACK_ARBITER_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = REQ_WAIT;
          w_d     = pick_idx;
          t_d     = req_intr[pick_idx];
        end
      end
      REQ_WAIT: begin
        if (eql) begin
          state_d = ACK_WAIT;
        end else if (!req[w_q]) begin
          state_d = IDLE;
          rr_d    = w_next;
        end
`ifdef IRQ_ACK_ARBITER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d   = IDLE;
          rr_d      = w_next;
          timeout_d = 1'b1;
        end
`endif
      end
      ACK_WAIT: begin
        if (!eql) begin
          state_d = DONE;
        end
`ifdef IRQ_ACK_ARBITER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d   = IDLE;
          rr_d      = w_next;
          timeout_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        rr_d    = w_next;
      end
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    grant_d  = (state_d == IDLE) ? '0 : onehot(w_d);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE) ? onehot(w_d) : '0;
    cc_mux_d = 2'b01;
    uscite_d = 2'b01;
    if (state_d == REQ_WAIT) begin
      cc_mux_d = t_d ? 2'b10 : 2'b01;
    end else if (state_d == ACK_WAIT) begin
      cc_mux_d = 2'b11;
      uscite_d = t_d ? 2'b11 : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      w_q      <= '0;
      t_q      <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      cc_mux_q <= 2'b01;
      uscite_q <= 2'b01;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      w_q      <= w_d;
      t_q      <= t_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      cc_mux_q <= cc_mux_d;
      uscite_q <= uscite_d;
      busy_q   <= busy_d;
    end
  end

`ifdef IRQ_ACK_ARBITER_TIMEOUT_EN
  // Restart on every entry into a wait state, count while staying there.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_d == REQ_WAIT || state_d == ACK_WAIT) && state_d == state_q) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant  = grant_q;
  assign done   = done_q;
  assign cc_mux = cc_mux_q;
  assign uscite = uscite_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_irq_ack_arbiter.sv
// Directed, table-driven bench for irq_ack_arbiter (NREQ=4, TMO_MAX=12).
// Covers the timeout path when IRQ_ACK_ARBITER_TIMEOUT_EN is defined, the indefinite wait otherwise.
module tb_irq_ack_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_intr;
  logic       eql;
  logic [3:0] grant;
  logic [1:0] cc_mux;
  logic [1:0] uscite;
  logic       busy;
  logic [3:0] done;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_intr;
    logic       eql;
    logic [3:0] e_grant;
    logic [1:0] e_cc;
    logic [1:0] e_us;
    logic       e_busy;
    logic [3:0] e_done;
    logic       e_tmo;
  } vec_t;

  vec_t vecs[$];

  irq_ack_arbiter #(.NREQ(4), .TMO_W(4), .TMO_MAX(12)) dut (
    .clk(clk), .rst(rst), .req(req), .req_intr(req_intr), .eql(eql),
    .grant(grant), .cc_mux(cc_mux), .uscite(uscite), .busy(busy),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] ri, logic e,
                              logic [3:0] g, logic [1:0] c, logic [1:0] u,
                              logic b, logic [3:0] d, logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.req_intr = ri; v.eql = e;
    v.e_grant = g; v.e_cc = c; v.e_us = u; v.e_busy = b; v.e_done = d; v.e_tmo = t;
    return v;
  endfunction

  // Drive inputs, let one rising edge sample them, then settle on the falling edge.
  task automatic applyStimulus(input logic r, input logic [3:0] rq,
                               input logic [3:0] ri, input logic e);
    rst = r; req = rq; req_intr = ri; eql = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmp(input string tag, input string name,
                     input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%h want=%h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] g, input logic [1:0] c,
                             input logic [1:0] u, input logic b, input logic [3:0] d,
                             input logic t);
    cmp(tag, "grant",   {4'b0, grant},   {4'b0, g});
    cmp(tag, "cc_mux",  {6'b0, cc_mux},  {6'b0, c});
    cmp(tag, "uscite",  {6'b0, uscite},  {6'b0, u});
    cmp(tag, "busy",    {7'b0, busy},    {7'b0, b});
    cmp(tag, "done",    {4'b0, done},    {4'b0, d});
    cmp(tag, "timeout", {7'b0, timeout}, {7'b0, t});
  endtask

  // Structural invariants checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (uscite === 2'b10 || !$onehot0(grant) || ((grant != 4'b0) !== busy) || !$onehot0(done)) begin
        bad++;
        $display("[TB] FAIL invariant grant=%b busy=%b uscite=%b done=%b at %0t",
                 grant, busy, uscite, done, $time);
      end
    end
  end

  initial begin
    logic [3:0] oh;

    // rst, req, req_intr, eql | grant, cc_mux, uscite, busy, done, timeout
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 2'b01, 2'b01, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 2'b01, 2'b01, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 2'b11, 2'b00, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 2'b01, 2'b01, 1, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0));
    // interrupt-type request on requester 2
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 2'b10, 2'b01, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 2'b11, 2'b11, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 2'b11, 2'b11, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 2'b01, 2'b01, 1, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0));
    // requester 1 withdraws before eql; pointer moves to 2 and wraps to 0
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 2'b01, 2'b01, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0001, 2'b01, 2'b01, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 4'b0001, 2'b11, 2'b00, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0001, 2'b01, 2'b01, 1, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0));
    // reset while in ACK_WAIT, then pointer restarts at 0 and finds requester 3
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 2'b01, 2'b01, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'b11, 2'b00, 1, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 0, 4'b1000, 2'b01, 2'b01, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 4'b1000, 2'b11, 2'b00, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 0, 4'b1000, 2'b01, 2'b01, 1, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0));

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].req_intr, vecs[i].eql);
      mon_en = 1'b1;
      checkOutput($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_cc, vecs[i].e_us,
                  vecs[i].e_busy, vecs[i].e_done, vecs[i].e_tmo);
    end

    // All four requesting continuously: grants rotate 0,1,2,3,0.
    $display("[TB] fairness sequence");
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      applyStimulus(0, 4'b1111, 4'b0000, 0);
      checkOutput($sformatf("fair%0d_req", k), oh, 2'b01, 2'b01, 1, 4'b0000, 0);
      applyStimulus(0, 4'b1111, 4'b0000, 1);
      checkOutput($sformatf("fair%0d_ack", k), oh, 2'b11, 2'b00, 1, 4'b0000, 0);
      applyStimulus(0, 4'b1111, 4'b0000, 0);
      checkOutput($sformatf("fair%0d_done", k), oh, 2'b01, 2'b01, 1, oh, 0);
      applyStimulus(0, 4'b1111, 4'b0000, 0);
      checkOutput($sformatf("fair%0d_idle", k), 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0);
    end

    // Pointer now at 1: requester 1 wins, then eql never arrives.
    $display("[TB] stalled handshake sequence");
    applyStimulus(0, 4'b0110, 4'b0000, 0);
    checkOutput("stall_grant", 4'b0010, 2'b01, 2'b01, 1, 4'b0000, 0);
`ifdef IRQ_ACK_ARBITER_TIMEOUT_EN
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(0, 4'b0110, 4'b0000, 0);
      checkOutput($sformatf("stall_wait%0d", i), 4'b0010, 2'b01, 2'b01, 1, 4'b0000, 0);
    end
    applyStimulus(0, 4'b0110, 4'b0000, 0);
    checkOutput("tmo_pulse", 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 1);
    applyStimulus(0, 4'b0110, 4'b0000, 0);
    checkOutput("tmo_next_grant", 4'b0100, 2'b01, 2'b01, 1, 4'b0000, 0);
`else
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 4'b0110, 4'b0000, 0);
      checkOutput($sformatf("stall_hold%0d", i), 4'b0010, 2'b01, 2'b01, 1, 4'b0000, 0);
    end
    applyStimulus(0, 4'b0000, 4'b0000, 0);
    checkOutput("stall_abort", 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 0);
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_ack_arbiter.md
Name: irq_ack_arbiter

Overview:
Round-robin arbiter that shares one interrupt/enable acknowledge handshake channel among NREQ requesters. It drives the handler-side mux code and status outputs, and sequences the equality handshake (eql) for the granted requester. It sits in front of the interrupt handler FSM and replaces direct point-to-point wiring of a single requester.

Parameters:
NREQ, 4, number of requesters (2..8)
TMO_W, 4, width of handshake timeout counter
TMO_MAX, 12, timeout limit in cycles (must fit in TMO_W bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  NREQ  request per requester; level, held until done
req_intr  input  NREQ  request type per requester; 1=interrupt, 0=enable-in; sampled with req
eql  input  1  handler equality/acknowledge
grant  output  NREQ  one-hot grant; all-zero when idle
cc_mux  output  2  handler mux code: 01 nop/enin, 10 intr, 11 ackin
uscite  output  2  status: 01 normal, 00 acknowledging enin, 11 acknowledging intr; never 10
busy  output  1  1 when state != IDLE
done  output  NREQ  one-cycle pulse on the completed requester's bit
timeout  output  1  one-cycle pulse on handshake abort (see Optional Feature)

Behaviour:
- All outputs registered. Reset values: grant=0, cc_mux=01, uscite=01, busy=0, done=0, timeout=0, state=IDLE, rr pointer=0, timeout counter=0.
- Reset mid-operation: the next edge with rst=1 returns everything to reset values; any in-flight grant is dropped with no done pulse.
- States:
  - IDLE: grant=0, cc_mux=01, uscite=01.
    - If req != 0 at an edge: pick winner w = first set bit scanning from rr pointer upward, wrapping at NREQ-1 -> 0.
    - Latch t = req_intr[w]. Grant registered at the same edge; go to REQ_WAIT.
    - Latency req->grant is 1 cycle.
  - REQ_WAIT: grant=onehot(w), cc_mux = t ? 10 : 01, uscite=01.
    - eql=1 -> ACK_WAIT.
    - Otherwise, req[w]=0 -> abort to IDLE; no done; rr pointer = w+1 mod NREQ.
  - ACK_WAIT: cc_mux=11, uscite = t ? 11 : 00.
    - Stay while eql=1. eql=0 -> DONE.
    - req[w] changes are ignored here.
  - DONE: done[w]=1 for exactly this cycle; grant still onehot(w); cc_mux=01, uscite=01.
    - Next edge -> IDLE; rr pointer = w+1 mod NREQ.
- Minimum grant-to-grant spacing: 4 cycles (REQ_WAIT, ACK_WAIT, DONE, IDLE).
- New requests are sampled only in IDLE. Requests arriving during a handshake wait.
- Fairness: with all NREQ requesting continuously, grant order is 0, 1, ..., NREQ-1, 0, ...
- Invariants:
  - grant is one-hot or zero.
  - grant != 0 iff busy.
  - uscite != 10 always.
  - done is nonzero only in DONE and is one-hot there.

Optional Feature:
- Macro: IRQ_ACK_ARBITER_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to REQ_WAIT and to ACK_WAIT, and increments each cycle spent in those states.
  - When it reaches TMO_MAX, the next edge returns to IDLE, timeout pulses 1 for one cycle (in IDLE), no done, and rr pointer = w+1 mod NREQ.
- Undefined: no counter logic; timeout is tied to 0; handshake waits indefinitely.

Test Plan:
- Reset, then req=0001, req_intr=0000; eql 0->1 two cycles later, 1->0 one cycle after that -> grant=0001 one cycle after req; cc_mux 01 -> 11 -> 01; uscite 01 -> 00 -> 01; done=0001 pulse once; busy back to 0.
- req=1111 held, eql handshake repeated -> grants in order 0001, 0010, 0100, 1000, 0001; each done bit pulses once per grant.
- req=0100 with req_intr[2]=1 -> cc_mux=10 in REQ_WAIT, uscite=11 in ACK_WAIT; uscite never 10 throughout.
- Grant to req[1], drop req[1] in REQ_WAIT before eql -> return to IDLE, no done; with req=0011 next, grant=0001 (pointer advanced to 2, wrapped to 0).
- rst=1 asserted while in ACK_WAIT -> next cycle grant=0, cc_mux=01, uscite=01, busy=0, no done; with req=1000 afterward, grant=1000 (pointer reset to 0, scan finds 3).
- With IRQ_ACK_ARBITER_TIMEOUT_EN, TMO_MAX=12, eql held 0 after grant -> timeout=1 pulse after 12 cycles in REQ_WAIT, then next requester is granted; without the macro, grant is held indefinitely and timeout stays 0.
